irq_source: RTL and testbench

The `irq_source` block is the device-side end of the hardware interrupt interface.
- It turns device event pulses into per-channel pending counts and drives the 8-bit `hardware_interrupt` level lines into cp0.
- It retires one pending event when cp0 vectors to that channel's handler.
- It sits between the peripheral bus and cp0, and receives cp0's `pc_jump` / `pc_addr` outputs as its acknowledge.

---
 rtl/irq_source.sv | 102 ++++++++++
 tb/tb_irq_source.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_source.sv
// Device-side interrupt source: counts device event edges per channel and retires one on cp0 vectoring.
// Optional macro IRQ_SOURCE_SYNC_EN adds a two-flop synchronizer ahead of the edge detector.
`ifndef CP0_INT_BASE
`define CP0_INT_BASE 32'h0000_0180
`endif

module irq_source #(
    parameter int          CNT_W    = 3,
    parameter logic [31:0] VEC_BASE = `CP0_INT_BASE
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [7:0]         dev_event,
    input  logic               pc_jump,
    input  logic [31:0]        pc_addr,
    input  logic               sw_clr_we,
    input  logic [7:0]         sw_clr_data,
    output logic [7:0]         hardware_interrupt,
    output logic [8*CNT_W-1:0] pending_cnt,
    output logic [7:0]         overflow
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [7:0]  w_cur;
    logic [7:0]  r_prev;
    logic [7:0]  w_evt;
    logic [7:0]  w_ack;
    logic        r_jump_q;
    logic        w_jump_edge;
    logic        w_ack_hit;
    logic [31:0] w_offset;

`ifdef IRQ_SOURCE_SYNC_EN
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= dev_event;
            r_sync2 <= r_sync1;
        end
    end

    assign w_cur = r_sync2;
`else
    assign w_cur = dev_event;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_prev   <= '0;
            r_jump_q <= 1'b0;
        end else begin
            r_prev   <= w_cur;
            r_jump_q <= pc_jump;
        end
    end

    assign w_evt       = w_cur & ~r_prev;
    assign w_jump_edge = pc_jump & ~r_jump_q;
    // Unsigned subtraction makes targets below the base wrap high and fall outside the window.
    assign w_offset    = pc_addr - VEC_BASE;
    assign w_ack_hit   = w_jump_edge && (w_offset < 32'd8);
    assign w_ack       = w_ack_hit ? (8'd1 << w_offset[2:0]) : 8'd0;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_ovf;

            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (sw_clr_we && sw_clr_data[gi]) begin
                    r_cnt <= w_evt[gi] ? CNT_ONE : '0;
                    r_ovf <= 1'b0;
                end else if (w_evt[gi] && !w_ack[gi]) begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end else if (w_ack[gi] && !w_evt[gi]) begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
            end

            assign hardware_interrupt[gi]         = |r_cnt;
            assign pending_cnt[gi*CNT_W +: CNT_W] = r_cnt;
            assign overflow[gi]                   = r_ovf;
        end
    endgenerate

endmodule

// File: tb/tb_irq_source.sv
// Directed bench for irq_source: expected snapshots are queued at stimulus and checked after latency.
module tb_irq_source;

    localparam int          CNT_W = 3;
    localparam logic [31:0] VB    = 32'h0000_2000;
`ifdef IRQ_SOURCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic               clk;
    logic               clr_n;
    logic [7:0]         dev_event;
    logic               pc_jump;
    logic [31:0]        pc_addr;
    logic               sw_clr_we;
    logic [7:0]         sw_clr_data;
    logic [7:0]         hardware_interrupt;
    logic [8*CNT_W-1:0] pending_cnt;
    logic [7:0]         overflow;

    irq_source #(.CNT_W(CNT_W), .VEC_BASE(VB)) dut (
        .clk(clk),
        .clr_n(clr_n),
        .dev_event(dev_event),
        .pc_jump(pc_jump),
        .pc_addr(pc_addr),
        .sw_clr_we(sw_clr_we),
        .sw_clr_data(sw_clr_data),
        .hardware_interrupt(hardware_interrupt),
        .pending_cnt(pending_cnt),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string              tag;
        logic [7:0]         hw;
        logic [8*CNT_W-1:0] cnt;
        logic [7:0]         ovf;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_mis = 0;
    int         exp_c[8];
    logic [7:0] exp_o;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (LAT) tick();
    endtask

    task automatic pulse(input logic [7:0] m);
        dev_event = m;
        tick();
        dev_event = 8'h00;
        tick();
    endtask

    task automatic do_jump(input logic [31:0] addr, input int hold);
        pc_addr = addr;
        pc_jump = 1'b1;
        repeat (hold) tick();
        pc_jump = 1'b0;
        tick();
    endtask

    task automatic exp_push(input string tag);
        exp_t e;
        e.tag = tag;
        e.ovf = exp_o;
        for (int i = 0; i < 8; i++) begin
            e.cnt[i*CNT_W +: CNT_W] = CNT_W'(exp_c[i]);
            e.hw[i] = (exp_c[i] != 0);
        end
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_mis++;
            $error("FAIL scoreboard_empty observed=0 expected>0");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            assert (pending_cnt === e.cnt) else begin
                n_mis++;
                $error("FAIL %s.cnt observed=%h expected=%h", e.tag, pending_cnt, e.cnt);
            end
            n_cmp++;
            assert (hardware_interrupt === e.hw) else begin
                n_mis++;
                $error("FAIL %s.hw observed=%h expected=%h", e.tag, hardware_interrupt, e.hw);
            end
            n_cmp++;
            assert (overflow === e.ovf) else begin
                n_mis++;
                $error("FAIL %s.ovf observed=%h expected=%h", e.tag, overflow, e.ovf);
            end
            $display("check %s: cnt=%h hw=%h ovf=%h", e.tag, pending_cnt, hardware_interrupt, overflow);
        end
    endtask

    task automatic expect_now(input string tag);
        exp_push(tag);
        check_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n = 1'b0; dev_event = 8'h00; pc_jump = 1'b0; pc_addr = 32'h0;
        sw_clr_we = 1'b0; sw_clr_data = 8'h00;
        for (int i = 0; i < 8; i++) exp_c[i] = 0;
        exp_o = 8'h00;
        repeat (3) tick();
        expect_now("reset_state");
        clr_n = 1'b1;
        tick();

        // Single event then ack held two cycles
        pulse(8'h08); settle();
        exp_c[3] = 1; expect_now("evt_ch3");
        pc_addr = VB + 32'd3; pc_jump = 1'b1;
        tick();
        exp_c[3] = 0; expect_now("ack_ch3_at_A");
        tick();
        pc_jump = 1'b0;
        tick();
        expect_now("ack_ch3_after_hold");

        // Held jump must retire exactly one event
        pulse(8'h08); pulse(8'h08); settle();
        exp_c[3] = 2; expect_now("ch3_two");
        do_jump(VB + 32'd3, 3);
        exp_c[3] = 1; expect_now("ch3_hold3_one_dec");
        do_jump(VB + 32'd3, 1);
        exp_c[3] = 0; expect_now("ch3_drained");

        // Saturation and software clear
        repeat (9) pulse(8'h01);
        settle();
        exp_c[0] = 7; exp_o[0] = 1'b1; expect_now("ch0_saturate");
        sw_clr_we = 1'b1; sw_clr_data = 8'h01;
        tick();
        sw_clr_we = 1'b0; sw_clr_data = 8'h00;
        exp_c[0] = 0; exp_o[0] = 1'b0; expect_now("ch0_sw_clear");

        // Simultaneous event and ack on ch5
        pulse(8'h20); pulse(8'h20); settle();
        exp_c[5] = 2; expect_now("ch5_two");
        pc_addr = VB + 32'd5;
        dev_event = 8'h20;
        for (int i = 0; i <= LAT; i++) begin
            if (i == LAT) pc_jump = 1'b1;
            tick();
            dev_event = 8'h00;
        end
        pc_jump = 1'b0;
        tick(); settle();
        expect_now("ch5_evt_and_ack");

        // Jumps outside the vector window, and ack on an empty channel
        do_jump(VB + 32'd8, 2);
        expect_now("jump_base_plus8");
        do_jump(VB - 32'd1, 2);
        expect_now("jump_base_minus1");
        do_jump(VB + 32'd2, 1);
        expect_now("ack_ch2_empty");

        // Clear and event together on ch1
        repeat (4) pulse(8'h02);
        settle();
        exp_c[1] = 4; expect_now("ch1_four");
        dev_event = 8'h02;
        for (int i = 0; i <= LAT; i++) begin
            if (i == LAT) begin
                sw_clr_we = 1'b1;
                sw_clr_data = 8'h02;
            end
            tick();
            dev_event = 8'h00;
        end
        sw_clr_we = 1'b0; sw_clr_data = 8'h00;
        settle();
        exp_c[1] = 1; expect_now("ch1_clear_plus_evt");

        // All-channel burst then asynchronous reset mid-cycle
        sw_clr_we = 1'b1; sw_clr_data = 8'hFF;
        tick();
        sw_clr_we = 1'b0; sw_clr_data = 8'h00;
        for (int i = 0; i < 8; i++) exp_c[i] = 0;
        expect_now("clear_all");
        pulse(8'hFF); settle();
        for (int i = 0; i < 8; i++) exp_c[i] = 1;
        expect_now("burst_all");
        #3;
        clr_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) exp_c[i] = 0;
        expect_now("async_reset_midcycle");

        // Line already high at reset release counts once, and not again while held
        dev_event = 8'h10;
        tick(); tick();
        clr_n = 1'b1;
        tick(); settle();
        exp_c[4] = 1; expect_now("high_at_release");
        repeat (3) tick();
        expect_now("no_retrigger_while_high");
        dev_event = 8'h00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
